mac_array_seq_ctrl: RTL and testbench

Sequencer for the ROW x COL array of mixed-precision MAC tiles. For one job it fetches weights from weight SRAM and issues kernel-load instructions, then fetches activations and issues execute instructions. It drains the array and signals completion. It also owns the array-wide mode_2b select, which is held stable for the whole job.

---
 rtl/mac_ctrl_pkg.sv | 18 +
 rtl/mac_array_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_mac_array_seq_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the MAC array sequencer: FSM state encoding and the
// array instruction encoding that the tiles decode.
package mac_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StGap   = 3'd2,
        StExec  = 3'd3,
        StDrain = 3'd4,
        StDone  = 3'd5
    } state_e;

    localparam logic [1:0] INST_NOP  = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

endpackage

// File: rtl/mac_array_seq_ctrl.sv
// Job sequencer for the ROW x COL MAC array: kernel load, execute, drain, done.
// Owns the array-wide precision select, held for the whole job.
module mac_array_seq_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int unsigned ROW     = 8,
    parameter int unsigned COL     = 8,
    parameter int unsigned ADDR_BW = 11,
    parameter int unsigned CNT_BW  = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic               i_cfg_mode_2b,
    input  logic [CNT_BW-1:0]  i_cfg_num_act,
    input  logic [ADDR_BW-1:0] i_cfg_w_base,
    input  logic [ADDR_BW-1:0] i_cfg_a_base,
    input  logic               i_ofifo_full,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_mode_2b,
    output logic               o_w_rd_en,
    output logic [ADDR_BW-1:0] o_w_rd_addr,
    output logic               o_a_rd_en,
    output logic [ADDR_BW-1:0] o_a_rd_addr,
    output logic [1:0]         o_inst_w
);

    localparam int unsigned PHASE_MAX = 2 * COL + ROW + COL;
    localparam int unsigned PHASE_W   = int'($clog2(PHASE_MAX)) + 1;
    localparam int unsigned CNT_W     = (CNT_BW > PHASE_W) ? CNT_BW : PHASE_W;

    state_e               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_BW-1:0]    r_num_act;
    logic                 r_mode_2b;
    logic                 r_w_en;
    logic                 r_a_req;
    logic                 r_busy;
    logic                 r_done;
    logic [ADDR_BW-1:0]   r_w_addr;
    logic [ADDR_BW-1:0]   r_a_addr;
    logic [1:0]           r_inst;

    logic                 w_a_rd_en;
    logic                 w_load_last;
    logic                 w_exec_last;
    logic                 w_drain_last;

    // Output FIFO back-pressure gates the activation read in the same cycle.
    assign w_a_rd_en    = r_a_req & ~i_ofifo_full;
    assign w_load_last  = (r_cnt == (r_mode_2b ? CNT_W'(2 * COL - 1) : CNT_W'(COL - 1)));
    assign w_exec_last  = (r_cnt == (CNT_W'(r_num_act) - CNT_W'(1)));
    assign w_drain_last = (r_cnt == CNT_W'(ROW + COL - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_num_act <= '0;
            r_mode_2b <= 1'b0;
            r_w_en    <= 1'b0;
            r_a_req   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_w_addr  <= '0;
            r_a_addr  <= '0;
            r_inst    <= INST_NOP;
        end else begin
            // Instruction lines up with SRAM data returning one cycle after the read.
            if (r_w_en) begin
                r_inst <= INST_LOAD;
            end else if (w_a_rd_en) begin
                r_inst <= INST_EXEC;
            end else begin
                r_inst <= INST_NOP;
            end
            r_done <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_mode_2b <= i_cfg_mode_2b;
                        r_num_act <= i_cfg_num_act;
                        r_w_addr  <= i_cfg_w_base;
                        r_a_addr  <= i_cfg_a_base;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_w_en    <= 1'b1;
                        r_state   <= StLoad;
                    end
                end
                StLoad: begin
                    r_w_addr <= r_w_addr + ADDR_BW'(1);
                    if (w_load_last) begin
                        r_cnt   <= '0;
                        r_w_en  <= 1'b0;
                        r_state <= StGap;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StGap: begin
                    r_cnt <= '0;
                    if (r_num_act == '0) begin
                        r_state <= StDrain;
                    end else begin
                        r_a_req <= 1'b1;
                        r_state <= StExec;
                    end
                end
                StExec: begin
                    if (!i_ofifo_full) begin
                        r_a_addr <= r_a_addr + ADDR_BW'(1);
                        if (w_exec_last) begin
                            r_cnt   <= '0;
                            r_a_req <= 1'b0;
                            r_state <= StDrain;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                StDrain: begin
                    if (w_drain_last) begin
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_mode_2b   = r_mode_2b;
    assign o_w_rd_en   = r_w_en;
    assign o_w_rd_addr = r_w_addr;
    assign o_a_rd_en   = w_a_rd_en;
    assign o_a_rd_addr = r_a_addr;
    assign o_inst_w    = r_inst;

endmodule

// File: tb/tb_mac_array_seq_ctrl.sv
// Directed bench for mac_array_seq_ctrl: per-cycle timeline comparison plus
// hand-computed job milestones (done cycle, read counts, final addresses).
module tb_mac_array_seq_ctrl;
    import mac_ctrl_pkg::*;

    localparam int unsigned ROW     = 8;
    localparam int unsigned COL     = 8;
    localparam int unsigned ADDR_BW = 11;
    localparam int unsigned CNT_BW  = 11;
    localparam int          MAXC    = 64;

    logic               clk = 1'b0;
    logic               reset;
    logic               i_start;
    logic               i_cfg_mode_2b;
    logic [CNT_BW-1:0]  i_cfg_num_act;
    logic [ADDR_BW-1:0] i_cfg_w_base;
    logic [ADDR_BW-1:0] i_cfg_a_base;
    logic               i_ofifo_full;
    logic               o_busy;
    logic               o_done;
    logic               o_mode_2b;
    logic               o_w_rd_en;
    logic [ADDR_BW-1:0] o_w_rd_addr;
    logic               o_a_rd_en;
    logic [ADDR_BW-1:0] o_a_rd_addr;
    logic [1:0]         o_inst_w;

    int checks = 0;
    int errors = 0;
    logic prev_mode = 1'b0;

    // Expected per-cycle timeline for the job under test.
    logic               e_busy  [MAXC];
    logic               e_done  [MAXC];
    logic               e_mode  [MAXC];
    logic               e_wen   [MAXC];
    logic               e_aen   [MAXC];
    logic               e_achk  [MAXC];
    logic [1:0]         e_inst  [MAXC];
    logic [ADDR_BW-1:0] e_waddr [MAXC];
    logic [ADDR_BW-1:0] e_aaddr [MAXC];

    mac_array_seq_ctrl #(
        .ROW     (ROW),
        .COL     (COL),
        .ADDR_BW (ADDR_BW),
        .CNT_BW  (CNT_BW)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_cfg_mode_2b (i_cfg_mode_2b),
        .i_cfg_num_act (i_cfg_num_act),
        .i_cfg_w_base  (i_cfg_w_base),
        .i_cfg_a_base  (i_cfg_a_base),
        .i_ofifo_full  (i_ofifo_full),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_mode_2b     (o_mode_2b),
        .o_w_rd_en     (o_w_rd_en),
        .o_w_rd_addr   (o_w_rd_addr),
        .o_a_rd_en     (o_a_rd_en),
        .o_a_rd_addr   (o_a_rd_addr),
        .o_inst_w      (o_inst_w)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int cyc, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got 0x%0h exp 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic build_model(input logic mode, input int na, input logic [ADDR_BW-1:0] wb,
                               input logic [ADDR_BW-1:0] ab, input int st_lo, input int st_hi,
                               input int rst_at, input int ncyc);
        int len;
        int t;
        int j;
        for (int c = 0; c < MAXC; c++) begin
            e_busy[c]  = 1'b0;
            e_done[c]  = 1'b0;
            e_mode[c]  = (c == 0) ? prev_mode : mode;
            e_wen[c]   = 1'b0;
            e_aen[c]   = 1'b0;
            e_achk[c]  = 1'b0;
            e_inst[c]  = INST_NOP;
            e_waddr[c] = '0;
            e_aaddr[c] = '0;
        end
        len = mode ? 2 * COL : COL;
        for (int c = 1; c <= len; c++) begin
            e_wen[c]   = 1'b1;
            e_waddr[c] = wb + ADDR_BW'(c - 1);
        end
        t = len + 2;
        j = 0;
        while (j < na && t < MAXC) begin
            e_achk[t]  = 1'b1;
            e_aaddr[t] = ab + ADDR_BW'(j);
            if (!(t >= st_lo && t <= st_hi)) begin
                e_aen[t] = 1'b1;
                j++;
            end
            t++;
        end
        t = t + ROW + COL;
        if (t < MAXC) e_done[t] = 1'b1;
        for (int c = 1; c <= t && c < MAXC; c++) e_busy[c] = 1'b1;
        for (int c = 1; c < MAXC; c++) begin
            if (e_wen[c-1]) e_inst[c] = INST_LOAD;
            else if (e_aen[c-1]) e_inst[c] = INST_EXEC;
        end
        if (rst_at >= 0) begin
            for (int c = rst_at + 1; c < MAXC; c++) begin
                e_busy[c] = 1'b0; e_done[c] = 1'b0; e_mode[c] = 1'b0;
                e_wen[c]  = 1'b0; e_aen[c]  = 1'b0; e_inst[c] = INST_NOP;
                e_achk[c] = 1'b0;
            end
        end
        if (ncyc >= MAXC) $fatal(1, "FAIL ncyc exceeds model depth");
    endtask

    // Cycle 0 of a job is the cycle in which start is driven.
    task automatic run_job(input string name, input logic mode, input int na,
                           input logic [ADDR_BW-1:0] wb, input logic [ADDR_BW-1:0] ab,
                           input int st_lo, input int st_hi, input int rst_at, input int sb_at,
                           input int ncyc, input int x_done, input int x_nw, input int x_nar,
                           input int x_last_a, input logic [ADDR_BW-1:0] x_last_w);
        int done_c = -1;
        int nw = 0;
        int nar = 0;
        int last_a = -1;
        int ndone = 0;
        logic [ADDR_BW-1:0] last_w = '0;
        build_model(mode, na, wb, ab, st_lo, st_hi, rst_at, ncyc);
        for (int c = 0; c <= ncyc; c++) begin
            reset   = (c == rst_at);
            i_start = (c == 0) || (c == sb_at);
            if (c == 0) begin
                i_cfg_mode_2b = mode;
                i_cfg_num_act = CNT_BW'(na);
                i_cfg_w_base  = wb;
                i_cfg_a_base  = ab;
            end else begin
                i_cfg_mode_2b = ~mode;
                i_cfg_num_act = CNT_BW'(9);
                i_cfg_w_base  = 11'h300;
                i_cfg_a_base  = 11'h500;
            end
            i_ofifo_full = (c >= st_lo && c <= st_hi);
            @(negedge clk);
            check_eq({name, ".ctl"}, c,
                     32'({o_busy, o_done, o_mode_2b, o_w_rd_en, o_a_rd_en, o_inst_w}),
                     32'({e_busy[c], e_done[c], e_mode[c], e_wen[c], e_aen[c], e_inst[c]}));
            if (e_wen[c]) check_eq({name, ".waddr"}, c, 32'(o_w_rd_addr), 32'(e_waddr[c]));
            if (e_achk[c]) check_eq({name, ".aaddr"}, c, 32'(o_a_rd_addr), 32'(e_aaddr[c]));
            if (o_done) begin
                ndone++;
                if (done_c < 0) done_c = c;
            end
            if (o_w_rd_en) begin
                nw++;
                last_w = o_w_rd_addr;
            end
            if (o_a_rd_en) begin
                nar++;
                last_a = c;
            end
            @(posedge clk);
            #1;
        end
        reset   = 1'b0;
        i_start = 1'b0;
        i_ofifo_full = 1'b0;
        check_eq({name, ".done_cyc"}, 0, 32'(done_c), 32'(x_done));
        check_eq({name, ".done_cnt"}, 0, 32'(ndone), (x_done < 0) ? 32'd0 : 32'd1);
        check_eq({name, ".n_wrd"}, 0, 32'(nw), 32'(x_nw));
        check_eq({name, ".n_ard"}, 0, 32'(nar), 32'(x_nar));
        check_eq({name, ".last_ard"}, 0, 32'(last_a), 32'(x_last_a));
        check_eq({name, ".last_waddr"}, 0, 32'(last_w), 32'(x_last_w));
        prev_mode = (rst_at >= 0) ? 1'b0 : mode;
    endtask

    initial begin
        reset         = 1'b1;
        i_start       = 1'b0;
        i_cfg_mode_2b = 1'b0;
        i_cfg_num_act = '0;
        i_cfg_w_base  = '0;
        i_cfg_a_base  = '0;
        i_ofifo_full  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("reset.ctl", 0,
                 32'({o_busy, o_done, o_mode_2b, o_w_rd_en, o_a_rd_en, o_inst_w}), 32'd0);
        check_eq("reset.addr", 0, 32'({o_w_rd_addr, o_a_rd_addr}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        //      name     mode na wb      ab      stall   rst  sb  ncyc done nw nar lastA lastW
        run_job("job4b",  0, 4, 11'h010, 11'h040, -1, -1, -1, -1, 32, 30,  8, 4, 13, 11'h017);
        run_job("job2b",  1, 4, 11'h010, 11'h040, -1, -1, -1, -1, 40, 38, 16, 4, 21, 11'h01F);
        run_job("stall",  0, 4, 11'h010, 11'h040, 11, 12, -1, -1, 34, 32,  8, 4, 15, 11'h017);
        run_job("noact",  0, 0, 11'h010, 11'h040, -1, -1, -1, -1, 28, 26,  8, 0, -1, 11'h017);
        run_job("busyst", 0, 4, 11'h010, 11'h040, -1, -1, -1, 12, 32, 30,  8, 4, 13, 11'h017);
        run_job("midrst", 0, 4, 11'h010, 11'h040, -1, -1, 12, -1, 16, -1,  8, 3, 12, 11'h017);
        run_job("after",  0, 4, 11'h010, 11'h040, -1, -1, -1, -1, 32, 30,  8, 4, 13, 11'h017);
        run_job("wrap",   0, 4, 11'h7FC, 11'h7FE, -1, -1, -1, -1, 32, 30,  8, 4, 13, 11'h003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
